// File: rtl/link_pkg.sv
// Shared definitions for the req/ack byte link receiver: rx state encoding
// and default link parameters.
package link_pkg;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t IDLE = 2'd0;
  localparam rx_state_t HOLD = 2'd1;
  localparam rx_state_t ACK  = 2'd2;

  localparam int LINK_DATA_W     = 8;
  localparam int LINK_FIFO_DEPTH = 4;
  localparam int LINK_ACK_HOLD   = 2;
  localparam int LINK_BURST_LEN  = 4;

endpackage

// File: rtl/link_rx_fifo.sv
// Synchronous FIFO for received link bytes. Pointers wrap modulo DEPTH
// (power of two); an occupancy counter gives full/empty/level.
module link_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [LW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign empty = (count == '0);
  assign full  = (count == LW'(DEPTH));
  assign level = count;
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/link_slave_rx.sv
// Receiving end of the 4-phase req/ack byte link: captures bytes, returns a
// registered ack, buffers into a FIFO and flags the end of each burst.
module link_slave_rx
  import link_pkg::*;
#(
  parameter int DATA_W     = LINK_DATA_W,
  parameter int FIFO_DEPTH = LINK_FIFO_DEPTH,
  parameter int ACK_HOLD   = LINK_ACK_HOLD,
  parameter int BURST_LEN  = LINK_BURST_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req,
  input  logic [DATA_W-1:0]             data,
  output logic                          ack,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          burst_done,
  output rx_state_t                     state
);

  localparam int HC_W = $clog2(ACK_HOLD + 1);
  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'(ACK_HOLD - 1);
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_LEN - 1);

  rx_state_t         next_state;
  logic [DATA_W-1:0] stage;
  logic [HC_W-1:0]   hold_cnt;
  logic [BC_W-1:0]   byte_cnt;
  logic              hold_done;
  logic              push_ok;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              stage_load;
  logic              fifo_empty;
  logic              fifo_full;

  link_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (rd_ready),
    .head      (rd_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign rd_valid  = !fifo_empty;
  assign push_ok   = !fifo_full || (rd_valid && rd_ready);
  assign hold_done = (hold_cnt >= HOLD_LAST);

  // State and datapath registers; ack is registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ack        <= 1'b0;
      stage      <= '0;
      hold_cnt   <= '0;
      byte_cnt   <= '0;
      burst_done <= 1'b0;
    end else begin
      state      <= next_state;
      ack        <= (next_state == ACK);
      burst_done <= push && (byte_cnt == BURST_LAST);
      if (stage_load) begin
        stage <= data;
      end
      if (state != ACK) begin
        hold_cnt <= '0;
      end else if (!hold_done) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (push) begin
        byte_cnt <= (byte_cnt == BURST_LAST) ? '0 : byte_cnt + 1'b1;
      end
    end
  end

  // A held req never restarts a capture: only IDLE looks at req to start one.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          next_state = push_ok ? ACK : HOLD;
        end
      end
      HOLD: begin
        if (push_ok) begin
          next_state = ACK;
        end
      end
      ACK: begin
        if (hold_done && !req) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // In IDLE the byte goes straight from the link into the FIFO; from HOLD it
  // comes out of the staging register.
  always_comb begin
    stage_load = 1'b0;
    push       = 1'b0;
    push_data  = stage;
    unique case (state)
      IDLE: begin
        stage_load = req;
        push       = req && push_ok;
        push_data  = data;
      end
      HOLD: begin
        push = push_ok;
      end
      default: begin
        push = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_link_slave_rx.sv
// Bench for link_slave_rx: directed master sequences push expected bytes into
// a queue; a negedge monitor pops and compares on every consumer handshake.
module tb_link_slave_rx;
  import link_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [7:0] data = '0;
  logic       ack;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [2:0] fifo_level;
  logic       burst_done;
  rx_state_t  state;

  logic       req2 = 1'b0;
  logic [7:0] data2 = '0;
  logic       ack2;
  logic [7:0] rd_data2;
  logic       rd_valid2;
  logic       rd_ready2 = 1'b1;
  logic [2:0] fifo_level2;
  logic       burst_done2;
  rx_state_t  state2;

  int checks = 0;
  int errors = 0;
  int burst_seen = 0;
  logic [7:0] exp_q[$];

  link_slave_rx u_dut (
    .clk (clk), .rst (rst), .req (req), .data (data), .ack (ack),
    .rd_data (rd_data), .rd_valid (rd_valid), .rd_ready (rd_ready),
    .fifo_level (fifo_level), .burst_done (burst_done), .state (state)
  );

  link_slave_rx #(.ACK_HOLD(1), .BURST_LEN(2)) u_dut2 (
    .clk (clk), .rst (rst), .req (req2), .data (data2), .ack (ack2),
    .rd_data (rd_data2), .rd_valid (rd_valid2), .rd_ready (rd_ready2),
    .fifo_level (fifo_level2), .burst_done (burst_done2), .state (state2)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse master: one-cycle req, then count how long ack stays high.
  task automatic pulse_byte(input logic [7:0] b);
    int n;
    req = 1'b1;
    data = b;
    exp_q.push_back(b);
    tick();
    req = 1'b0;
    data = 'x;
    n = 0;
    while (ack && n < 20) begin
      n++;
      tick();
    end
    chk("ack_len", n, 2);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (burst_done === 1'b1) burst_seen++;
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got %0h with empty expected queue", rd_data);
      end else begin
        chk("rd_data", int'(rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ack", int'(ack), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_burst", int'(burst_done), 0);
    chk("rst_state", int'(state), int'(IDLE));

    // 1: pulse master, consumer always ready
    rd_ready = 1'b1;
    pulse_byte(8'hA0);
    pulse_byte(8'hA1);
    pulse_byte(8'hA2);
    pulse_byte(8'hA3);
    tick();
    chk("t1_bursts", burst_seen, 1);
    chk("t1_level", int'(fifo_level), 0);

    // 2: consumer stalled, fifth byte held off
    rd_ready = 1'b0;
    pulse_byte(8'hB0);
    pulse_byte(8'hB1);
    pulse_byte(8'hB2);
    pulse_byte(8'hB3);
    chk("t2_level_full", int'(fifo_level), 4);
    req = 1'b1;
    data = 8'hB4;
    exp_q.push_back(8'hB4);
    tick();
    req = 1'b0;
    data = 'x;
    chk("t2_hold_state", int'(state), int'(HOLD));
    chk("t2_hold_ack", int'(ack), 0);
    tick();
    tick();
    chk("t2_still_hold", int'(state), int'(HOLD));
    chk("t2_still_noack", int'(ack), 0);

    // 4: pop and staged push in the same cycle
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("t4_ack_rise", int'(ack), 1);
    chk("t4_level_same", int'(fifo_level), 4);
    n = 0;
    while (ack && n < 20) begin
      n++;
      tick();
    end
    chk("t4_ack_len", n, 2);
    rd_ready = 1'b1;
    n = 0;
    while (rd_valid && n < 20) begin
      n++;
      tick();
    end
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_bursts", burst_seen, 2);

    // 3: level req held high for 6 cycles
    req = 1'b1;
    data = 8'hC0;
    exp_q.push_back(8'hC0);
    tick();
    data = 8'hEE;
    for (int i = 1; i <= 5; i++) begin
      chk("t3_ack_high", int'(ack), 1);
      tick();
    end
    req = 1'b0;
    data = 'x;
    chk("t3_ack_after_fall", int'(ack), 1);
    tick();
    chk("t3_ack_low", int'(ack), 0);
    repeat (3) tick();
    chk("t3_one_byte", exp_q.size(), 0);
    chk("t3_level", int'(fifo_level), 0);
    chk("t3_state", int'(state), int'(IDLE));

    // 5: reset mid-handshake
    pulse_byte(8'hC1);
    rd_ready = 1'b0;
    pulse_byte(8'hD0);
    chk("t5_bursts_before", burst_seen, 3);
    req = 1'b1;
    data = 8'hD1;
    exp_q.push_back(8'hD1);
    tick();
    req = 1'b0;
    data = 'x;
    chk("t5_pre_ack", int'(ack), 1);
    chk("t5_pre_level", int'(fifo_level), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("t5_ack", int'(ack), 0);
    chk("t5_rd_valid", int'(rd_valid), 0);
    chk("t5_level", int'(fifo_level), 0);
    chk("t5_state", int'(state), int'(IDLE));
    rd_ready = 1'b1;
    pulse_byte(8'hE0);
    pulse_byte(8'hE1);
    pulse_byte(8'hE2);
    tick();
    chk("t5_no_early_burst", burst_seen, 3);
    pulse_byte(8'hE3);
    tick();
    chk("t5_burst_after_e3", burst_seen, 4);
    chk("t5_drained", exp_q.size(), 0);

    // 6: second instance, ACK_HOLD=1, BURST_LEN=2
    for (int k = 0; k < 4; k++) begin
      req2 = 1'b1;
      data2 = 8'hF0 + 8'(k);
      tick();
      req2 = 1'b0;
      data2 = 'x;
      chk("t6_ack_high", int'(ack2), 1);
      chk("t6_rd_valid", int'(rd_valid2), 1);
      chk("t6_rd_data", int'(rd_data2), 'hF0 + k);
      chk("t6_burst", int'(burst_done2), k % 2);
      tick();
      chk("t6_ack_low", int'(ack2), 0);
    end

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
